// File: rtl/rf_pkg.sv
// Shared sizes and types for the register-file write-side controller.
package rf_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS);
    localparam int unsigned DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_addr_t rd;
        reg_data_t data;
    } wb_req_t;

    typedef enum logic {
        SRC_WB0 = 1'b0,
        SRC_WB1 = 1'b1
    } wb_src_t;

endpackage

// File: rtl/rf_wb_arbiter.sv
// Two-source writeback arbiter feeding a one-entry valid/ready output stage.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    wb0_valid_i,
    output logic    wb0_ready_o,
    input  wb_req_t wb0_req_i,
    input  logic    wb1_valid_i,
    output logic    wb1_ready_o,
    input  wb_req_t wb1_req_i,
    output logic    rf_valid_o,
    input  logic    rf_ready_i,
    output wb_req_t rf_req_o
);

    wb_src_t last_q;
    logic    rf_valid_q;
    wb_req_t rf_req_q;
    logic    slot_free;
    logic    pick1;
    logic    grant0;
    logic    grant1;
    wb_req_t win_req;

    always_comb begin
        slot_free = !rf_valid_q || rf_ready_i;
        // wb1 wins when alone, or when contested and wb0 had the previous turn
        pick1     = wb1_valid_i && (!wb0_valid_i || (RR_EN && (last_q == SRC_WB0)));
        grant0    = slot_free && wb0_valid_i && !pick1;
        grant1    = slot_free && pick1;
        win_req   = pick1 ? wb1_req_i : wb0_req_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= SRC_WB1;
            rf_valid_q <= 1'b0;
            rf_req_q   <= '0;
        end else if (grant0 || grant1) begin
            last_q     <= grant1 ? SRC_WB1 : SRC_WB0;
            // x0 writes are consumed here and never reach the register file
            rf_valid_q <= (win_req.rd != '0);
            if (win_req.rd != '0) begin
                rf_req_q <= win_req;
            end
        end else if (rf_ready_i) begin
            rf_valid_q <= 1'b0;
        end
    end

    assign wb0_ready_o = grant0;
    assign wb1_ready_o = grant1;
    assign rf_valid_o  = rf_valid_q;
    assign rf_req_o    = rf_req_q;

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register-file write-side controller: writeback arbitration plus busy scoreboard
// that stalls issue on RAW/WAW hazards until the pending write commits.
module regfile_wb_scoreboard
    import rf_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [ADDR_W-1:0]   issue_rs1_i,
    input  logic [ADDR_W-1:0]   issue_rs2_i,
    input  logic [ADDR_W-1:0]   issue_rd_i,
    input  logic                issue_we_i,
    input  logic                wb0_valid_i,
    output logic                wb0_ready_o,
    input  logic [ADDR_W-1:0]   wb0_rd_i,
    input  logic [DATA_W-1:0]   wb0_data_i,
    input  logic                wb1_valid_i,
    output logic                wb1_ready_o,
    input  logic [ADDR_W-1:0]   wb1_rd_i,
    input  logic [DATA_W-1:0]   wb1_data_i,
    output logic                rf_valid_o,
    input  logic                rf_ready_i,
    output logic                rf_wr_en_o,
    output logic [ADDR_W-1:0]   rf_rd_addr_o,
    output logic [DATA_W-1:0]   rf_rd_data_o,
    output logic [NUM_REGS-1:0] busy_o
);

    localparam logic [NUM_REGS-1:0] X0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    wb_req_t             wb0_req;
    wb_req_t             wb1_req;
    wb_req_t             rf_req;

    assign wb0_req = '{rd: wb0_rd_i, data: wb0_data_i};
    assign wb1_req = '{rd: wb1_rd_i, data: wb1_data_i};

    rf_wb_arbiter #(
        .RR_EN (RR_EN)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wb0_valid_i (wb0_valid_i),
        .wb0_ready_o (wb0_ready_o),
        .wb0_req_i   (wb0_req),
        .wb1_valid_i (wb1_valid_i),
        .wb1_ready_o (wb1_ready_o),
        .wb1_req_i   (wb1_req),
        .rf_valid_o  (rf_valid_o),
        .rf_ready_i  (rf_ready_i),
        .rf_req_o    (rf_req)
    );

    assign rf_wr_en_o   = rf_valid_o;
    assign rf_rd_addr_o = rf_req.rd;
    assign rf_rd_data_o = rf_req.data;

    // Registered busy only: a commit becomes visible to issue one cycle later
    assign issue_ready_o = !busy_q[issue_rs1_i] && !busy_q[issue_rs2_i]
                        && !(issue_we_i && busy_q[issue_rd_i]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid_i && issue_ready_o && issue_we_i && (issue_rd_i != '0)) begin
            set_vec[issue_rd_i] = 1'b1;
        end
        if (rf_valid_o && rf_ready_i) begin
            clr_vec[rf_rd_addr_o] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clr_vec) | set_vec) & X0_MASK;
        end
    end

    assign busy_o = busy_q;

endmodule
